// File: rtl/branch_predictor_if.sv
// Fetch-lookup and branch-resolution bundle between fetch, branch unit and predictor.
// master drives fetch_pc/upd_*/flush_all; slave returns prediction and perf counters.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        flush_all;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken,
    output upd_target, upd_pred_taken, flush_all,
    input  pred_taken, pred_target, br_count, mispred_count
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken,
    input  upd_target, upd_pred_taken, flush_all,
    output pred_taken, pred_target, br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup, edge update.
// Ports: clk, rst_n (async low), bp (slave: fetch lookup, update, perf counters).
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic clk,
  input  logic rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];
  logic [31:0]        br_cnt;
  logic [31:0]        mp_cnt;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             f_hit;
  logic             u_hit;
  logic             f_taken;
  logic             train;

  assign f_idx = bp.fetch_pc[IDX_W+1:2];
  assign f_tag = bp.fetch_pc[31:IDX_W+2];
  assign u_idx = bp.upd_pc[IDX_W+1:2];
  assign u_tag = bp.upd_pc[31:IDX_W+2];

  logic unused_lo;
  assign unused_lo = ^bp.upd_pc[1:0];

  assign f_hit   = valid[f_idx] && (tag[f_idx] == f_tag);
  assign u_hit   = valid[u_idx] && (tag[u_idx] == u_tag);
  assign f_taken = f_hit && ctr[f_idx][1];

  assign bp.pred_taken    = f_taken;
  assign bp.pred_target   = f_taken ? target[f_idx]
                                    : bp.fetch_pc + 32'd4;
  assign bp.br_count      = br_cnt;
  assign bp.mispred_count = mp_cnt;

  // Flush takes priority over training/allocation.
  assign train = bp.upd_valid && !bp.flush_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (bp.flush_all) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (train) begin
      unique case (1'b1)
        u_hit && bp.upd_taken: begin
          if (ctr[u_idx] != 2'b11) ctr[u_idx] <= ctr[u_idx] + 2'd1;
        end
        u_hit && !bp.upd_taken: begin
          if (ctr[u_idx] != 2'b00) ctr[u_idx] <= ctr[u_idx] - 2'd1;
        end
        !u_hit && bp.upd_taken: begin
          valid[u_idx] <= 1'b1;
          ctr[u_idx]   <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  // Tag/target carry no reset: they are meaningless while valid=0.
  // A taken update rewrites both on hit (tag unchanged) and on allocate.
  always_ff @(posedge clk) begin
    if (train && bp.upd_taken) begin
      tag[u_idx]    <= u_tag;
      target[u_idx] <= bp.upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (bp.upd_valid) begin
      br_cnt <= br_cnt + 32'd1;
      if (bp.upd_pred_taken != bp.upd_taken)
        mp_cnt <= mp_cnt + 32'd1;
    end
  end
endmodule
